// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: turns one execute-stage request into a valid/ready bus transaction.
// Min latency start->done is 3 cycles (1 for rejected requests); each bus wait cycle adds one.
module ysyx_23060111_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        m_ren,
  input  logic [31:0] m_raddr,
  input  logic        m_wen,
  input  logic [31:0] m_waddr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_wmask,
  output logic [31:0] m_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    FIN   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  strb_q, strb_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_err;
  logic [3:0]  req_strb;
  logic [4:0]  byte_sh;

  assign byte_sh = {addr_q[1:0], 3'b000};

  // Loads fetch the containing word and shift it down, so only stores are alignment-checked.
  always_comb begin
    req_err  = 1'b0;
    req_strb = 4'b0000;
    unique case (m_wmask)
      32'd1:   req_strb = 4'b0001;
      32'd2:   req_strb = 4'b0011;
      32'd4:   req_strb = 4'b1111;
      default: req_strb = 4'b0000;
    endcase
    if (m_ren && m_wen) begin
      req_err = 1'b1;
    end else if (m_wen) begin
      unique case (m_wmask)
        32'd1:   req_err = 1'b0;
        32'd2:   req_err = m_waddr[0];
        32'd4:   req_err = |m_waddr[1:0];
        default: req_err = 1'b1;
      endcase
    end else if (!m_ren) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = m_ren ? m_raddr : m_waddr;
          wdat_d = m_wdata;
          strb_d = req_strb;
          err_d  = req_err;
          if (req_err)    state_d = FIN;
          else if (m_ren) state_d = RADDR;
          else            state_d = WREQ;
        end
      end
      RADDR: if (arready) state_d = RDATA;
      RDATA: begin
        if (rvalid) begin
          rdata_d = rdata >> byte_sh;
          state_d = FIN;
        end
      end
      WREQ:  if (wready) state_d = WRESP;
      WRESP: if (bvalid) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdat_q  <= 32'h0;
      strb_q  <= 4'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign err     = done & err_q;
  assign m_rdata = rdata_q;

  // Bus outputs are forced to zero outside their own state so idle/reset values are clean.
  assign arvalid = (state_q == RADDR);
  assign araddr  = arvalid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign rready  = (state_q == RDATA);
  assign wvalid  = (state_q == WREQ);
  assign waddr   = wvalid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign wdata   = wvalid ? (wdat_q << byte_sh) : 32'h0;
  assign wstrb   = wvalid ? (strb_q << addr_q[1:0]) : 4'h0;
  assign bready  = (state_q == WRESP);

endmodule
